sc_stream_decoder: RTL and testbench

SC_STREAM_DECODER -- requirements
Module: sc_stream_decoder

---
 rtl/sc_stream_decoder_if.sv | 23 ++
 rtl/sc_stream_decoder.sv | 86 ++++++++
 tb/tb_sc_stream_decoder.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sc_stream_decoder_if.sv
// Stream handshake bundle for the stochastic decoder.
// master drives samples and accepts results; slave is the decoder.
interface sc_stream_decoder_if #(
  parameter int DATA_W = 8
);
  logic              start;
  logic              in_bit;
  logic              in_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_value;
  logic              out_valid;
  logic              busy;

  modport master (
    output start, in_bit, in_valid, out_ready,
    input  out_value, out_valid, busy
  );

  modport slave (
    input  start, in_bit, in_valid, out_ready,
    output out_value, out_valid, busy
  );
endinterface

// File: rtl/sc_stream_decoder.sv
// Unipolar stochastic bitstream to binary decoder.
// Counts ones over a 2^LOG_LEN valid-sample window.
module sc_stream_decoder #(
  parameter int DATA_W  = 8,
  parameter int LOG_LEN = 8
) (
  input logic clk,
  input logic rst_n,
  sc_stream_decoder_if.slave bus
);
  localparam int SH = DATA_W - LOG_LEN;
  localparam logic [LOG_LEN:0] LAST =
    {1'b0, {LOG_LEN{1'b1}}};

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    DONE
  } state_t;

  state_t             state;
  logic [LOG_LEN:0]   smp;
  logic [LOG_LEN:0]   ones;
  logic [LOG_LEN:0]   ones_nxt;
  logic [DATA_W:0]    scaled;
  logic [DATA_W-1:0]  sat;
  logic [DATA_W-1:0]  value_q;
  logic               valid_q;

  // Ones count including the sample on the current cycle.
  always_comb begin
    ones_nxt = ones + {{LOG_LEN{1'b0}}, bus.in_bit};
    scaled   = (DATA_W+1)'(ones_nxt) << SH;
    sat      = scaled[DATA_W] ? '1
                              : scaled[DATA_W-1:0];
  end

  // Window FSM with registered result and handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      smp     <= '0;
      ones    <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            smp   <= '0;
            ones  <= '0;
            state <= COUNT;
          end
        end
        COUNT: begin
          if (bus.in_valid) begin
            smp  <= smp + 1'b1;
            ones <= ones_nxt;
            if (smp == LAST) begin
              state   <= DONE;
              valid_q <= 1'b1;
              value_q <= sat;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            valid_q <= 1'b0;
            if (bus.start) begin
              smp   <= '0;
              ones  <= '0;
              state <= COUNT;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out_value = value_q;
  assign bus.out_valid = valid_q;
  assign bus.busy      = (state == COUNT);
endmodule

// File: tb/tb_sc_stream_decoder.sv
// Directed bench for sc_stream_decoder.
// Two instances: LOG_LEN=8 and LOG_LEN=4.
module tb_sc_stream_decoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  sc_stream_decoder_if #(.DATA_W(8)) b8 ();
  sc_stream_decoder_if #(.DATA_W(8)) b4 ();

  sc_stream_decoder #(
    .DATA_W(8), .LOG_LEN(8)
  ) u8 (.clk(clk), .rst_n(rst_n), .bus(b8));

  sc_stream_decoder #(
    .DATA_W(8), .LOG_LEN(4)
  ) u4 (.clk(clk), .rst_n(rst_n), .bus(b4));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit pat(input int m, input int i);
    case (m)
      0: pat = (i % 2) == 1;
      1: pat = 1'b1;
      2: pat = 1'b0;
      3: pat = i < 64;
      4: pat = (i % 4) == 0;
      default: pat = 1'b0;
    endcase
  endfunction

  task automatic start8();
    b8.start = 1'b1;
    step();
    b8.start = 1'b0;
  endtask

  task automatic feed8(input int m, input int lo,
                       input int hi);
    for (int i = lo; i < hi; i++) begin
      b8.in_valid = 1'b1;
      b8.in_bit   = pat(m, i);
      step();
    end
    b8.in_valid = 1'b0;
    b8.in_bit   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    b8.start = 1'b1; b8.in_valid = 1'b1;
    b8.in_bit = 1'b1; b8.out_ready = 1'b1;
    b4.start = 1'b1; b4.in_valid = 1'b1;
    b4.in_bit = 1'b1; b4.out_ready = 1'b1;
    step(); step();
    n_chk += 6;
    if (b8.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst busy8 got %b want 0", b8.busy);
    end
    if (b8.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst valid8 got %b want 0",
               b8.out_valid);
    end
    if (b8.out_value !== 8'd0) begin
      n_fail++;
      $display("FAIL rst value8 got %0d want 0",
               b8.out_value);
    end
    if (b4.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst busy4 got %b want 0", b4.busy);
    end
    if (b4.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst valid4 got %b want 0",
               b4.out_valid);
    end
    if (b4.out_value !== 8'd0) begin
      n_fail++;
      $display("FAIL rst value4 got %0d want 0",
               b4.out_value);
    end
    b8.start = 0; b8.in_valid = 0; b8.in_bit = 0;
    b8.out_ready = 0;
    b4.start = 0; b4.in_valid = 0; b4.in_bit = 0;
    b4.out_ready = 0;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_half();
    start8();
    n_chk++;
    if (b8.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL half busy got %b want 1", b8.busy);
    end
    feed8(0, 0, 255);
    n_chk++;
    if (b8.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL half early valid got %b want 0",
               b8.out_valid);
    end
    feed8(0, 255, 256);
    n_chk += 3;
    if (b8.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL half latency valid got %b want 1",
               b8.out_valid);
    end
    if (b8.out_value !== 8'd128) begin
      n_fail++;
      $display("FAIL half value got %0d want 128",
               b8.out_value);
    end
    if (b8.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL half done busy got %b want 0",
               b8.busy);
    end
    b8.out_ready = 1'b1;
    step();
    b8.out_ready = 1'b0;
    step();
    n_chk += 2;
    if (b8.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL half accept valid got %b want 0",
               b8.out_valid);
    end
    if (b8.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL half idle busy got %b want 0",
               b8.busy);
    end
  endtask

  task automatic test_saturate();
    start8();
    feed8(1, 0, 256);
    n_chk++;
    if (b8.out_valid !== 1'b1 || b8.out_value !== 8'd255)
    begin
      n_fail++;
      $display("FAIL sat ones got %b/%0d want 1/255",
               b8.out_valid, b8.out_value);
    end
    b8.out_ready = 1'b1;
    step();
    b8.out_ready = 1'b0;
    start8();
    feed8(2, 0, 256);
    n_chk++;
    if (b8.out_valid !== 1'b1 || b8.out_value !== 8'd0)
    begin
      n_fail++;
      $display("FAIL sat zeros got %b/%0d want 1/0",
               b8.out_valid, b8.out_value);
    end
    b8.out_ready = 1'b1;
    step();
    b8.out_ready = 1'b0;
  endtask

  task automatic test_gapped();
    int vi;
    vi = 0;
    b4.start = 1'b1;
    step();
    b4.start = 1'b0;
    for (int c = 0; c < 31; c++) begin
      if (c == 30) begin
        n_chk++;
        if (b4.out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL gap early valid got %b want 0",
                   b4.out_valid);
        end
      end
      b4.in_valid = (c % 2) == 0;
      b4.in_bit   = ((c % 2) == 0) && (vi < 5);
      if ((c % 2) == 0) vi++;
      step();
    end
    b4.in_valid = 1'b0;
    b4.in_bit   = 1'b0;
    n_chk += 2;
    if (b4.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL gap valid got %b want 1",
               b4.out_valid);
    end
    if (b4.out_value !== 8'd80) begin
      n_fail++;
      $display("FAIL gap value got %0d want 80",
               b4.out_value);
    end
    b4.out_ready = 1'b1;
    step();
    b4.out_ready = 1'b0;
  endtask

  task automatic test_hold_back_to_back();
    start8();
    feed8(3, 0, 256);
    for (int k = 0; k < 10; k++) begin
      b8.start = (k % 3) == 0;
      step();
      n_chk++;
      if (b8.out_valid !== 1'b1 ||
          b8.out_value !== 8'd64 || b8.busy !== 1'b0)
      begin
        n_fail++;
        $display("FAIL hold cyc %0d got %b/%0d/%b %s",
                 k, b8.out_valid, b8.out_value, b8.busy,
                 "want 1/64/0");
      end
    end
    b8.start = 1'b1;
    b8.out_ready = 1'b1;
    step();
    b8.out_ready = 1'b0;
    n_chk += 3;
    if (b8.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b busy got %b want 1", b8.busy);
    end
    if (b8.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b valid got %b want 0",
               b8.out_valid);
    end
    if (b8.out_value !== 8'd64) begin
      n_fail++;
      $display("FAIL b2b value got %0d want 64",
               b8.out_value);
    end
    for (int i = 0; i < 256; i++) begin
      b8.start    = (i >= 20) && (i < 40);
      b8.in_valid = 1'b1;
      b8.in_bit   = i < 10;
      step();
    end
    b8.start = 0; b8.in_valid = 0; b8.in_bit = 0;
    n_chk++;
    if (b8.out_valid !== 1'b1 || b8.out_value !== 8'd10)
    begin
      n_fail++;
      $display("FAIL nostart got %b/%0d want 1/10",
               b8.out_valid, b8.out_value);
    end
    b8.out_ready = 1'b1;
    step();
    b8.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    start8();
    feed8(1, 0, 100);
    rst_n = 1'b0;
    b8.in_valid = 1'b1;
    b8.in_bit = 1'b1;
    step();
    rst_n = 1'b1;
    b8.in_valid = 1'b0;
    b8.in_bit = 1'b0;
    n_chk += 3;
    if (b8.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid busy got %b want 0", b8.busy);
    end
    if (b8.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid valid got %b want 0",
               b8.out_valid);
    end
    if (b8.out_value !== 8'd0) begin
      n_fail++;
      $display("FAIL mid value got %0d want 0",
               b8.out_value);
    end
    feed8(1, 0, 200);
    n_chk++;
    if (b8.out_valid !== 1'b0 || b8.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid ghost got %b/%b want 0/0",
               b8.out_valid, b8.busy);
    end
    start8();
    feed8(4, 0, 256);
    n_chk++;
    if (b8.out_valid !== 1'b1 || b8.out_value !== 8'd64)
    begin
      n_fail++;
      $display("FAIL mid redo got %b/%0d want 1/64",
               b8.out_valid, b8.out_value);
    end
    b8.out_ready = 1'b1;
    step();
    b8.out_ready = 1'b0;
  endtask

  task automatic test_sng();
    logic [7:0] lfsr;
    int d;
    lfsr = 8'h01;
    start8();
    for (int i = 0; i < 256; i++) begin
      b8.in_valid = 1'b1;
      b8.in_bit   = lfsr < 8'hA0;
      step();
      lfsr = {lfsr[6:0],
              lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
    b8.in_valid = 1'b0;
    b8.in_bit   = 1'b0;
    d = int'(b8.out_value) - 160;
    if (d < 0) d = -d;
    n_chk++;
    if (b8.out_valid !== 1'b1 || d > 8) begin
      n_fail++;
      $display("FAIL sng got %b/%0d want 1/160+-8",
               b8.out_valid, b8.out_value);
    end
    b8.out_ready = 1'b1;
    step();
    b8.out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_half();
    test_saturate();
    test_gapped();
    test_hold_back_to_back();
    test_reset_mid();
    test_sng();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
